// File: rtl/fact_seq.sv
// Iterative factorial engine: n! mod 2^RES_W, one multiply per clock.
// Owns the select line of the upstream accumulator mux (0 = load 1, 1 = product feedback).
//
// state | meaning
// IDLE  | waiting for start; sel=0 presents the initial value 1 to the accumulator
// MULT  | one multiply per clock, cnt counts down to the terminal value 1
// DONE  | one-cycle result-valid pulse, then back to IDLE
module fact_seq #(
    parameter int N_W   = 8,
    parameter int RES_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N_W-1:0]   n,
    output logic             busy,
    output logic             done,
    output logic [RES_W-1:0] result,
    output logic             overflow,
    output logic             sel
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [RES_W-1:0]     acc;
    logic [RES_W-1:0]     acc_mux;
    logic [N_W-1:0]       cnt;
    logic [RES_W+N_W-1:0] prod;
    logic                 last;

    // Terminal count: cnt of 0 or 1 ends the multiply chain.
    assign last    = (cnt <= N_W'(1));
    assign prod    = {{N_W{1'b0}}, acc} * {{RES_W{1'b0}}, cnt};
    assign acc_mux = sel ? prod[RES_W-1:0] : RES_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        sel       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = MULT;
                end
            end
            MULT: begin
                busy = 1'b1;
                sel  = 1'b1;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc      <= RES_W'(1);
            cnt      <= '0;
            result   <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc      <= acc_mux;
                        cnt      <= n;
                        overflow <= 1'b0;
                    end
                end
                MULT: begin
                    if (last) begin
                        result <= acc;
                    end else begin
                        acc      <= acc_mux;
                        cnt      <= cnt - N_W'(1);
                        overflow <= overflow | (|prod[RES_W+N_W-1:RES_W]);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
